// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state type, default floor count and floor-index width helper
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DOOR
  } state_e;

  localparam int NUM_FLOORS_DEFAULT = 8;

  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FLOOR_W = floor_w(NUM_FLOORS_DEFAULT);

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - button-register link: request bitmap in, one-hot clear pulse out
interface elevator_if import elevator_pkg::*; #(
  parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
);
  logic [NUM_FLOORS-1:0] req;
  logic                  req_valid;
  logic [NUM_FLOORS-1:0] clr;

  modport master (output req, output req_valid, input clr);
  modport slave  (input req, input req_valid, output clr);
endinterface

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - loadable down-counter shared by the travel and door phases
module elevator_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] count_q, count_d;

  // Load wins over counting so a phase can be restarted on its own terminal cycle.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  assign done = en && (count_q == W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - single-car IDLE/MOVING/DOOR controller
// Optional emergency stop input enabled by ELEVATOR_CTRL_ESTOP_EN.
module elevator_controller import elevator_pkg::*; #(
  parameter int  NUM_FLOORS  = NUM_FLOORS_DEFAULT,
  parameter int  MOVE_CYCLES = 16,
  parameter int  DOOR_CYCLES = 32,
  localparam int FW = floor_w(NUM_FLOORS),
  localparam int TW = $clog2(((MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          reset,
`ifdef ELEVATOR_CTRL_ESTOP_EN
  input  logic          estop,
`endif
  elevator_if.slave     bus,
  output logic [FW-1:0] floor,
  output logic          dir_up,
  output logic          moving,
  output logic          door_open
);
  localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);

  state_e          state_q, state_d;
  logic [FW-1:0]   floor_q, floor_d;
  logic            dir_up_q, dir_up_d;
  logic            door_first_q, door_first_d;
  logic            tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]   tmr_val;
  logic [NUM_FLOORS-1:0] req_g;
  logic [FW-1:0]   step_floor;
  logic            above, here, below;
  logic            n_above, n_here, n_below;
  logic            eff_up, halt;

`ifdef ELEVATOR_CTRL_ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  // {above, here, below} relative to floor f
  function automatic logic [2:0] scan(input logic [NUM_FLOORS-1:0] r, input logic [FW-1:0] f);
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(f)) a |= r[i];
      if (i < int'(f)) b |= r[i];
    end
    return {a, r[f], b};
  endfunction

  assign req_g      = bus.req & {NUM_FLOORS{bus.req_valid}};
  assign step_floor = dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
  assign {above, here, below}       = scan(req_g, floor_q);
  assign {n_above, n_here, n_below} = scan(req_g, step_floor);
  assign eff_up = (floor_q == TOP) ? 1'b0 : (floor_q == '0) ? 1'b1 : dir_up_q;
  assign tmr_en = (state_q != IDLE) && !halt;

  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      door_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      door_first_q <= door_first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    door_first_d = door_first_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    if (!halt) begin
      unique case (state_q)
        IDLE: begin
          if (here) begin
            state_d      = DOOR;
            dir_up_d     = eff_up;
            door_first_d = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = TW'(DOOR_CYCLES);
          end else if (eff_up ? above : below) begin
            state_d  = MOVING;
            dir_up_d = eff_up;
            tmr_load = 1'b1;
            tmr_val  = TW'(MOVE_CYCLES);
          end else if (eff_up ? below : above) begin
            state_d  = MOVING;
            dir_up_d = !eff_up;
            tmr_load = 1'b1;
            tmr_val  = TW'(MOVE_CYCLES);
          end
        end
        MOVING: begin
          if (tmr_done) begin
            floor_d = step_floor;
            if (n_here) begin
              state_d      = DOOR;
              door_first_d = 1'b1;
              tmr_load     = 1'b1;
              tmr_val      = TW'(DOOR_CYCLES);
            end else if (dir_up_q ? n_above : n_below) begin
              tmr_load = 1'b1;
              tmr_val  = TW'(MOVE_CYCLES);
            end else begin
              state_d = IDLE;
            end
          end
        end
        DOOR: begin
          // The button register still shows this floor during the clear cycle; only a later press retriggers.
          if (!door_first_q && here) begin
            door_first_d = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = TW'(DOOR_CYCLES);
          end else begin
            door_first_d = 1'b0;
            if (tmr_done) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.clr   = '0;
    if ((state_q == DOOR) && door_first_q && !halt) begin
      bus.clr = NUM_FLOORS'(1) << floor_q;
    end
    moving    = (state_q == MOVING) && !halt;
    door_open = (state_q == DOOR);
    floor     = floor_q;
    dir_up    = dir_up_q;
  end
endmodule

// File: tb/tb_elevator_controller.sv
// tb/tb_elevator_controller.sv - vector table, directed trips and randomized run against a behavioural model
module tb_elevator_controller;
  localparam int NF = 8;
  localparam int MC = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] floor;
  logic       dir_up, moving, door_open;
`ifdef ELEVATOR_CTRL_ESTOP_EN
  logic       estop = 1'b0;
`endif

  elevator_if #(.NUM_FLOORS(NF)) bus ();

  elevator_controller #(.NUM_FLOORS(NF), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ELEVATOR_CTRL_ESTOP_EN
    .estop     (estop),
`endif
    .bus       (bus),
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       vld;
    int         n;
    int         fl;
    logic [7:0] clr;
    logic       mv;
    logic       door;
    logic       up;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [7:0] req, logic vld, int n,
                              int fl, logic [7:0] clr, logic mv, logic door, logic up);
    vec_t v;
    v.rst = rst; v.req = req; v.vld = vld; v.n = n;
    v.fl = fl; v.clr = clr; v.mv = mv; v.door = door; v.up = up;
    return v;
  endfunction

  function automatic logic [13:0] dut_out();
    return {floor, bus.clr, moving, door_open, dir_up};
  endfunction

  // Behavioural reference: mode 0 idle, 1 travelling, 2 door; left = cycles remaining in the phase
  int m_mode, m_floor, m_left;
  bit m_up, m_fresh;

  function automatic bit any_dir(logic [7:0] r, int f, bit up);
    for (int i = 0; i < NF; i++) begin
      if ((up ? (i > f) : (i < f)) && r[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic open_door();
    m_mode = 2; m_left = DC; m_fresh = 1'b1;
  endtask

  task automatic model_step(input bit rst, input logic [7:0] r, input bit es);
    bit u;
    if (rst) begin
      m_mode = 0; m_floor = 0; m_up = 1'b1; m_left = 0; m_fresh = 1'b0;
      return;
    end
    if (es) return;
    case (m_mode)
      0: begin
        u = (m_floor == NF - 1) ? 1'b0 : (m_floor == 0) ? 1'b1 : m_up;
        if (r[m_floor]) begin m_up = u; open_door(); end
        else if (any_dir(r, m_floor, u)) begin m_up = u; m_mode = 1; m_left = MC; end
        else if (any_dir(r, m_floor, !u)) begin m_up = !u; m_mode = 1; m_left = MC; end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (r[m_floor]) open_door();
          else if (any_dir(r, m_floor, m_up)) m_left = MC;
          else m_mode = 0;
        end
      end
      default: begin
        if (!m_fresh && r[m_floor]) open_door();
        else begin
          m_fresh = 1'b0;
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  function automatic logic [13:0] model_out(input bit es);
    logic [7:0] c;
    c = (m_mode == 2 && m_fresh && !es) ? 8'(1 << m_floor) : 8'h00;
    return {3'(m_floor), c, (m_mode == 1 && !es), (m_mode == 2), m_up};
  endfunction

  task automatic do_reset();
    reset = 1'b1; bus.req = '0; bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pending, last_clr, clr_seen, ev_clr[4];
    int mv, dr, nclr, fl_seen, nev, ev_fl[4], k;
    bit done, switched, ev_up[4], rst, vld, es;

    reset = 1'b1; bus.req = '0; bus.req_valid = 1'b0;
    @(negedge clk);

    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 20, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h01, 1,  1, 0, 8'h01, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 8'h01, 1,  1, 0, 8'h01, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0,  2, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h01, 0,  2, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h04, 1,  4, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h04, 1,  4, 1, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h04, 1,  1, 2, 8'h04, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0,  2, 2, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0,  1, 2, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h01, 1,  4, 2, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h01, 1,  4, 1, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h01, 1,  1, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0,  2, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 1,  4, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h80, 1,  4, 1, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h80, 1,  4, 2, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h80, 1,  4, 3, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h80, 1,  2, 4, 8'h00, 1, 0, 1));
    tbl.push_back(mk(1, 8'h80, 1,  1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0,  2, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h01, 1,  1, 0, 8'h01, 0, 1, 1));
    tbl.push_back(mk(1, 8'h00, 0,  1, 0, 8'h00, 0, 0, 1));

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        reset = tbl[i].rst; bus.req = tbl[i].req; bus.req_valid = tbl[i].vld;
        @(negedge clk);
        check($sformatf("vec[%0d].%0d", i, c), 32'(dut_out()),
              32'({3'(tbl[i].fl), tbl[i].clr, tbl[i].mv, tbl[i].door, tbl[i].up}));
      end
    end

    // Trip 0 -> 5: 20 travel cycles, one clear pulse, three door cycles.
    do_reset();
    pending = 8'h20; mv = 0; dr = 0; nclr = 0; done = 0; clr_seen = '0; fl_seen = -1;
    for (int c = 0; c < 100 && !done; c++) begin
      bus.req = pending; bus.req_valid = |pending;
      @(negedge clk);
      if (moving) mv++;
      if (door_open) dr++;
      if (bus.clr != '0) begin nclr++; clr_seen = bus.clr; fl_seen = floor; end
      pending &= ~bus.clr;
      if (dr > 0 && !door_open && !moving) done = 1;
    end
    check("trip5_done", 32'(done), 32'd1);
    check("trip5_move_cycles", 32'(mv), 32'd20);
    check("trip5_clr_count", 32'(nclr), 32'd1);
    check("trip5_clr", 32'(clr_seen), 32'h20);
    check("trip5_floor", 32'(fl_seen), 32'd5);
    check("trip5_door_cycles", 32'(dr), 32'd3);

    // Upward with 0x80, replaced at floor 3 by 0x42: stop at 6, then reverse to 1.
    do_reset();
    pending = 8'h80; switched = 0; nev = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      bus.req = pending; bus.req_valid = |pending;
      @(negedge clk);
      if (!switched && moving && floor == 3) begin pending = 8'h42; switched = 1; end
      if (bus.clr != '0) begin
        if (nev < 4) begin ev_clr[nev] = bus.clr; ev_fl[nev] = floor; ev_up[nev] = dir_up; end
        nev++;
      end
      pending &= ~bus.clr;
      if (switched && pending == '0 && !door_open && !moving) done = 1;
    end
    check("rev_done", 32'(done), 32'd1);
    check("rev_stops", 32'(nev), 32'd2);
    if (nev == 2) begin
      check("rev_clr0", 32'(ev_clr[0]), 32'h40);
      check("rev_floor0", 32'(ev_fl[0]), 32'd6);
      check("rev_clr1", 32'(ev_clr[1]), 32'h02);
      check("rev_floor1", 32'(ev_fl[1]), 32'd1);
      check("rev_dir1", 32'(ev_up[1]), 32'd0);
    end

`ifdef ELEVATOR_CTRL_ESTOP_EN
    // Freeze one cycle into floor 2; two travel cycles must remain after release.
    do_reset();
    bus.req = 8'h20; bus.req_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!(floor == 2 && moving) && k < 50);
    check("estop_reach2", 32'(floor), 32'd2);
    @(negedge clk);
    estop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("estop_hold.%0d", c), 32'({floor, moving, bus.clr}), 32'({3'd2, 1'b0, 8'h00}));
    end
    estop = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (floor == 2 && k < 20);
    check("estop_resume_cycles", 32'(k), 32'd3);
    check("estop_resume_state", 32'({floor, moving}), 32'({3'd3, 1'b1}));
`endif

    // Randomized run with a button register cleared by the expected clear pulse.
    pending = '0; last_clr = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 399) == 0);
      vld = ($urandom_range(0, 7) != 0);
`ifdef ELEVATOR_CTRL_ESTOP_EN
      es = ($urandom_range(0, 15) == 0);
      estop = es;
`else
      es = 1'b0;
`endif
      reset = rst; bus.req = pending; bus.req_valid = vld;
      model_step(rst, vld ? pending : 8'h00, es);
      pending &= ~last_clr;
      if ($urandom_range(0, 9) == 0) pending |= 8'(1 << $urandom_range(0, NF - 1));
      @(negedge clk);
      check($sformatf("rand.%0d", c), 32'(dut_out()), 32'(model_out(es)));
      last_clr = model_out(es)[10:3];
    end
    reset = 1'b0;
`ifdef ELEVATOR_CTRL_ESTOP_EN
    estop = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors; floors are numbered 0..NUM_FLOORS-1.
REQ-002 Parameter MOVE_CYCLES, default 16, clock cycles spent travelling between adjacent floors (minimum 1).
REQ-003 Parameter DOOR_CYCLES, default 32, clock cycles the door stays open (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_FLOORS  pending-request bitmap from the button register.
REQ-007 req_valid  input  1  high when req is nonzero; req SHALL be treated as all-zero while req_valid is low.
REQ-008 clr  output  NUM_FLOORS  one-hot clear pulse sent back to the button register.
REQ-009 floor  output  clog2(NUM_FLOORS)  current floor.
REQ-010 dir_up  output  1  travel or preference direction: 1 up, 0 down.
REQ-011 moving  output  1  high in state MOVING.
REQ-012 door_open  output  1  high in state DOOR.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MOVING and DOOR.
REQ-014 "Above" means any gated req bit with index greater than floor; "below" means any bit with index less than floor; "here" means req[floor].
REQ-015 IDLE: here -> DOOR; else a request in the dir_up direction -> MOVING in that direction; else a request in the opposite direction -> flip dir_up, then MOVING; else stay IDLE.
REQ-016 MOVING: the floor timer counts MOVE_CYCLES cycles; on the terminal cycle floor steps by ±1 per dir_up.
REQ-017 On the terminal cycle of MOVING, the next state SHALL be decided using the new floor: here -> DOOR; else a request beyond the new floor in dir_up -> MOVING with the timer reloaded; else IDLE.
REQ-018 In the first cycle of DOOR, clr SHALL equal one-hot(floor) for exactly one cycle; clr SHALL be zero in every other cycle.
REQ-019 DOOR: the timer counts DOOR_CYCLES cycles, then the FSM goes to IDLE.
REQ-020 If req[floor] reasserts while in DOOR, clr SHALL pulse again in the next cycle and the door timer SHALL restart.
REQ-021 floor SHALL never leave 0..NUM_FLOORS-1; at floor NUM_FLOORS-1 dir_up SHALL be forced to 0, and at floor 0 it SHALL be forced to 1, when leaving IDLE.
REQ-022 Request bits cleared externally during MOVING SHALL be honoured at the next decision point; no stop is made for a bit no longer set.

Reset
REQ-023 Reset SHALL set: state IDLE, floor 0, dir_up 1, moving 0, door_open 0, clr 0, timer 0.
REQ-024 Reset SHALL take priority over all activity, including in mid-MOVING or mid-DOOR.

Configuration
REQ-025 Macro ELEVATOR_CTRL_ESTOP_EN, when defined, SHALL add input estop (1 bit, active-high).
REQ-026 While estop is high: state, floor and timer SHALL hold; moving SHALL read 0; clr SHALL read 0; door_open SHALL keep its value.
REQ-027 When ELEVATOR_CTRL_ESTOP_EN is undefined, the estop port and its logic SHALL be absent.

Structure
REQ-028 Package elevator_pkg SHALL hold the state enum, NUM_FLOORS_DEFAULT and the FLOOR_W function/constant.
REQ-029 Sub-module elevator_timer (load, count value, done pulse) SHALL serve both the move and door timers.

Verification (NUM_FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-030 Reset, then req=0x00 for 20 cycles -> floor=0, state IDLE, clr never asserted.
REQ-031 req=0x20 at floor 0 -> moving for 20 cycles, floor=5, then clr=0x20 for one cycle, door_open for 3 cycles, then IDLE.
REQ-032 At floor 3 moving up, req=0x42 -> stop at 6 with clr=0x40, then reverse, stop at 1 with clr=0x02.
REQ-033 req=0x01 at floor 0 -> DOOR on the next cycle with clr=0x01 and no movement; reasserting during DOOR produces a second clr pulse and restarts the 3-cycle timer.
REQ-034 Reset asserted mid-MOVING at floor 4 -> next cycle floor=0, moving=0, clr=0.
REQ-035 With ELEVATOR_CTRL_ESTOP_EN defined, estop high for 10 cycles mid-move -> floor and timer frozen, moving=0; travel resumes with the remaining cycles after release.
